// File: rtl/expr_result_sig_pkg.sv
// Shared constants, field map and state type for the expression result capture stage.
package expr_pkg;

    localparam int          RES_W      = 90;
    localparam int          NUM_FIELDS = 18;
    localparam int          SIG_W      = 32;
    localparam int          CNT_W      = 16;
    localparam logic [31:0] POLY       = 32'h04C11DB7;

    // Field 0 is the most significant slice of the bus; widths repeat 4,5,6,4,5,6.
    localparam int FIELD_LSB [NUM_FIELDS] = '{86, 81, 75, 71, 66, 60,
                                              56, 51, 45, 41, 36, 30,
                                              26, 21, 15, 11,  6,  0};
    localparam int FIELD_W   [NUM_FIELDS] = '{ 4,  5,  6,  4,  5,  6,
                                               4,  5,  6,  4,  5,  6,
                                               4,  5,  6,  4,  5,  6};

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    function automatic logic [RES_W-1:0] field_mask(input int idx);
        logic [RES_W-1:0] m;
        m = '0;
        for (int b = 0; b < RES_W; b++) begin
            if (b >= FIELD_LSB[idx] && b < FIELD_LSB[idx] + FIELD_W[idx]) begin
                m[b] = 1'b1;
            end
        end
        return m;
    endfunction

endpackage

// File: rtl/expr_result_sig_if.sv
// Result beat stream: DUT result and golden expected value under valid/ready.
interface expr_result_sig_if #(
    parameter int W = 90
);
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] in_y;
    logic [W-1:0] in_exp;

    modport master (output in_valid, output in_y, output in_exp, input in_ready);
    modport slave  (input in_valid, input in_y, input in_exp, output in_ready);
endinterface

// File: rtl/expr_result_sig_field_cmp.sv
// Per-field compare of result against expected; reports the lowest-numbered differing field.
module expr_field_cmp
    import expr_pkg::*;
(
    input  logic [RES_W-1:0] in_y,
    input  logic [RES_W-1:0] in_exp,
    output logic             any_diff,
    output logic [4:0]       first_field
);

    logic [RES_W-1:0] diff;

    assign diff     = in_y ^ in_exp;
    assign any_diff = |diff;

    // Walk from the last field down so field 0 wins when several differ.
    always_comb begin
        first_field = 5'd31;
        for (int i = NUM_FIELDS - 1; i >= 0; i--) begin
            if ((diff & field_mask(i)) != '0) begin
                first_field = 5'(i);
            end
        end
    end

endmodule

// File: rtl/expr_result_sig.sv
// Capture stage: compares result beats to expected, counts mismatches and folds results into a MISR.
module expr_result_sig
    import expr_pkg::*;
#(
    parameter int               W      = 90,
    parameter int               SIG_W  = 32,
    parameter logic [SIG_W-1:0] POLY   = 32'h04C11DB7,
    parameter int               CNT_W  = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic [CNT_W-1:0]    num_vec,
    expr_result_sig_if.slave    bus,
    output logic                busy,
    output logic                done,
    output logic [CNT_W-1:0]    mismatch_cnt,
    output logic [CNT_W-1:0]    first_bad_idx,
    output logic [4:0]          first_bad_field,
    output logic [SIG_W-1:0]    signature
);

    state_t           state, state_nxt;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] num_lat;
    logic [W-1:0]     beat_y;
    logic [W-1:0]     beat_exp;
    logic             accept;
    logic             last_beat;
    logic             any_diff;
    logic [4:0]       first_field;
    logic [SIG_W-1:0] fold;
    logic [SIG_W-1:0] sig_next;

    assign beat_y       = bus.in_y;
    assign beat_exp     = bus.in_exp;
    assign bus.in_ready = (state == RUN);
    assign busy         = (state == RUN);
    assign done         = (state == DONE);
    assign accept       = bus.in_valid && bus.in_ready;
    assign last_beat    = (cnt == num_lat - CNT_W'(1));

    expr_field_cmp u_cmp (
        .in_y        (beat_y),
        .in_exp      (beat_exp),
        .any_diff    (any_diff),
        .first_field (first_field)
    );

    // The signature depends on the DUT result only, so a golden run reproduces it without in_exp.
    assign fold     = beat_y[31:0] ^ beat_y[63:32] ^ {6'b0, beat_y[89:64]};
    assign sig_next = {signature[SIG_W-2:0], 1'b0} ^ (signature[SIG_W-1] ? POLY : '0) ^ fold;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE, DONE: begin
                if (start) begin
                    state_nxt = (num_vec == '0) ? DONE : RUN;
                end
            end
            RUN: begin
                if (accept && last_beat) begin
                    state_nxt = DONE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // A non-zero mismatch count doubles as the "first mismatch already recorded" flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt             <= '0;
            num_lat         <= '0;
            mismatch_cnt    <= '0;
            first_bad_idx   <= '0;
            first_bad_field <= 5'd31;
            signature       <= '0;
        end else if (state != RUN) begin
            if (start) begin
                cnt             <= '0;
                num_lat         <= num_vec;
                mismatch_cnt    <= '0;
                first_bad_idx   <= '0;
                first_bad_field <= 5'd31;
                signature       <= '0;
            end
        end else if (accept) begin
            cnt       <= cnt + CNT_W'(1);
            signature <= sig_next;
            if (any_diff) begin
                if (mismatch_cnt != '1) begin
                    mismatch_cnt <= mismatch_cnt + CNT_W'(1);
                end
                if (mismatch_cnt == '0) begin
                    first_bad_idx   <= cnt;
                    first_bad_field <= first_field;
                end
            end
        end
    end

endmodule

// File: tb/tb_expr_result_sig.sv
// Directed bench for expr_result_sig: single-beat vector table plus multi-beat run sequences.
module tb_expr_result_sig;
    import expr_pkg::*;

    typedef struct {
        string       name;
        logic [89:0] y;
        logic [89:0] exp;
        logic [31:0] sig;
        logic [15:0] mis;
        logic [4:0]  field;
    } vec_t;

    logic        clk;
    logic        rst;
    logic        start;
    logic [15:0] num_vec;
    logic        busy;
    logic        done;
    logic [15:0] mismatch_cnt;
    logic [15:0] first_bad_idx;
    logic [4:0]  first_bad_field;
    logic [31:0] signature;

    int total;
    int bad;

    expr_result_sig_if #(.W(90)) bus ();

    expr_result_sig dut (
        .clk             (clk),
        .rst             (rst),
        .start           (start),
        .num_vec         (num_vec),
        .bus             (bus.slave),
        .busy            (busy),
        .done            (done),
        .mismatch_cnt    (mismatch_cnt),
        .first_bad_idx   (first_bad_idx),
        .first_bad_field (first_bad_field),
        .signature       (signature)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] misrRef(input logic [31:0] sig, input logic [89:0] y);
        logic [31:0] f;
        logic [31:0] s;
        f = y[31:0] ^ y[63:32] ^ {6'b0, y[89:64]};
        s = sig << 1;
        if (sig[31]) s = s ^ 32'h04C11DB7;
        return s ^ f;
    endfunction

    task automatic checkOutput(input string name, input logic [95:0] act, input logic [95:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("[TB] FAIL %s: got %0h required %0h", name, act, req);
        end
    endtask

    task automatic checkReset(input string tag);
        checkOutput({tag, " in_ready"}, 96'(bus.in_ready), 96'(0));
        checkOutput({tag, " busy"}, 96'(busy), 96'(0));
        checkOutput({tag, " done"}, 96'(done), 96'(0));
        checkOutput({tag, " mismatch_cnt"}, 96'(mismatch_cnt), 96'(0));
        checkOutput({tag, " first_bad_idx"}, 96'(first_bad_idx), 96'(0));
        checkOutput({tag, " first_bad_field"}, 96'(first_bad_field), 96'(31));
        checkOutput({tag, " signature"}, 96'(signature), 96'(0));
    endtask

    task automatic startRun(input logic [15:0] n);
        start   = 1'b1;
        num_vec = n;
        @(negedge clk);
        start   = 1'b0;
        num_vec = 16'hBEEF;
    endtask

    // Idles for 'gap' cycles with garbage data, then delivers one beat once in_ready is seen.
    task automatic applyStimulus(input logic [89:0] y, input logic [89:0] exp, input int gap);
        int wait_cnt;
        for (int g = 0; g < gap; g++) begin
            bus.in_valid = 1'b0;
            bus.in_y     = {26'($urandom), $urandom, $urandom};
            bus.in_exp   = {26'($urandom), $urandom, $urandom};
            @(negedge clk);
        end
        wait_cnt = 0;
        while (!bus.in_ready && wait_cnt < 50) begin
            @(negedge clk);
            wait_cnt++;
        end
        if (!bus.in_ready) begin
            total++;
            bad++;
            $display("[TB] FAIL ready_timeout: got in_ready=0 required 1 within 50 cycles");
        end else begin
            bus.in_valid = 1'b1;
            bus.in_y     = y;
            bus.in_exp   = exp;
            @(negedge clk);
            bus.in_valid = 1'b0;
        end
    endtask

    vec_t        vecs [10];
    logic [89:0] run_y [4];
    logic [31:0] ref_sig;
    logic [89:0] b89, b0;

    initial begin
        total = 0;
        bad   = 0;
        b89   = 90'h1 << 89;
        b0    = 90'h1;

        vecs[0] = '{"eq_one",      90'h1,                  90'h1,                     32'h00000001, 16'd0, 5'd31};
        vecs[1] = '{"bit89_f0",    b89,                    90'h0,                     32'h02000000, 16'd1, 5'd0};
        vecs[2] = '{"bit0_f17",    90'h0,                  b0,                        32'h00000000, 16'd1, 5'd17};
        vecs[3] = '{"fold_cancel", (90'h1 << 32) | b0,     (90'h1 << 32) | b0,        32'h00000000, 16'd0, 5'd31};
        vecs[4] = '{"bit45_f8",    90'h0,                  90'h1 << 45,               32'h00000000, 16'd1, 5'd8};
        vecs[5] = '{"bit11_f15",   90'h1 << 40,            (90'h1 << 40) | (90'h1 << 11), 32'h00000100, 16'd1, 5'd15};
        vecs[6] = '{"f11_vs_f12",  (90'h3 << 29),          90'h0,                     32'h60000000, 16'd1, 5'd11};
        vecs[7] = '{"all_ones",    {90{1'b1}},             {90{1'b1}},                32'h03FFFFFF, 16'd0, 5'd31};
        vecs[8] = '{"f5_edges",    (90'h1 << 65) | (90'h1 << 60), 90'h0,              32'h10000002, 16'd1, 5'd5};
        vecs[9] = '{"bit66_f4",    90'h1 << 66,            90'h0,                     32'h00000004, 16'd1, 5'd4};

        rst          = 1'b1;
        start        = 1'b0;
        num_vec      = 16'd0;
        bus.in_valid = 1'b0;
        bus.in_y     = '0;
        bus.in_exp   = '0;

        // Reset held for three cycles, checked while held and after release
        repeat (3) @(posedge clk);
        @(negedge clk);
        checkReset("rst_held");
        rst = 1'b0;
        @(negedge clk);
        checkReset("rst_released");

        // Single beat, equal data
        startRun(16'd1);
        checkOutput("t2 busy", 96'(busy), 96'(1));
        applyStimulus(90'h1, 90'h1, 0);
        checkOutput("t2 done", 96'(done), 96'(1));
        checkOutput("t2 signature", 96'(signature), 96'h00000001);
        checkOutput("t2 mismatch_cnt", 96'(mismatch_cnt), 96'(0));

        // Two beats exercising the feedback tap
        startRun(16'd2);
        applyStimulus(90'h8000_0000, 90'h8000_0000, 0);
        checkOutput("t3 done_early", 96'(done), 96'(0));
        applyStimulus(90'h0, 90'h0, 0);
        checkOutput("t3 done", 96'(done), 96'(1));
        checkOutput("t3 signature", 96'(signature), 96'h04C11DB7);

        // Three beats, beat 1 differs at bits 89 and 0, start pulse mid-run must be ignored
        startRun(16'd3);
        applyStimulus(90'h5, 90'h5, 0);
        startRun(16'd0);
        checkOutput("t4 busy_after_start", 96'(busy), 96'(1));
        applyStimulus(90'h123 ^ b89 ^ b0, 90'h123, 1);
        checkOutput("t4 busy_mid", 96'(busy), 96'(1));
        applyStimulus(90'h0, 90'h0, 0);
        ref_sig = misrRef(misrRef(misrRef(32'h0, 90'h5), 90'h123 ^ b89 ^ b0), 90'h0);
        checkOutput("t4 done", 96'(done), 96'(1));
        checkOutput("t4 mismatch_cnt", 96'(mismatch_cnt), 96'(1));
        checkOutput("t4 first_bad_idx", 96'(first_bad_idx), 96'(1));
        checkOutput("t4 first_bad_field", 96'(first_bad_field), 96'(0));
        checkOutput("t4 signature", 96'(signature), 96'(ref_sig));

        // Zero-length run goes straight to DONE with cleared state
        startRun(16'd0);
        for (int c = 0; c < 3; c++) begin
            checkOutput("t5 in_ready", 96'(bus.in_ready), 96'(0));
            checkOutput("t5 done", 96'(done), 96'(1));
            bus.in_valid = 1'b1;
            bus.in_y     = 90'h7;
            @(negedge clk);
            bus.in_valid = 1'b0;
        end
        checkOutput("t5 signature", 96'(signature), 96'(0));
        checkOutput("t5 first_bad_field", 96'(first_bad_field), 96'(31));

        // Table of single-beat runs
        for (int i = 0; i < 10; i++) begin
            startRun(16'd1);
            applyStimulus(vecs[i].y, vecs[i].exp, 0);
            checkOutput({vecs[i].name, " done"}, 96'(done), 96'(1));
            checkOutput({vecs[i].name, " signature"}, 96'(signature), 96'(vecs[i].sig));
            checkOutput({vecs[i].name, " mismatch_cnt"}, 96'(mismatch_cnt), 96'(vecs[i].mis));
            checkOutput({vecs[i].name, " first_bad_field"}, 96'(first_bad_field), 96'(vecs[i].field));
            checkOutput({vecs[i].name, " first_bad_idx"}, 96'(first_bad_idx), 96'(0));
        end

        // Gapped run aborted by reset, then rerun with gaps against a gap-free reference
        run_y[0] = 90'h3_0000_0000_8000_0001;
        run_y[1] = 90'h2AA_AAAA_5555_5555_AAAA;
        run_y[2] = 90'h1FF_FFFF_0000_0000_FFFF;
        run_y[3] = 90'h0_1234_5678_9ABC_DEF0;
        ref_sig = 32'h0;
        for (int i = 0; i < 4; i++) ref_sig = misrRef(ref_sig, run_y[i]);

        startRun(16'd4);
        applyStimulus(run_y[0], run_y[0] ^ 90'h1, int'($urandom_range(0, 4)));
        applyStimulus(run_y[1], run_y[1], int'($urandom_range(0, 4)));
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checkReset("t6 abort");

        startRun(16'd4);
        for (int i = 0; i < 4; i++) begin
            applyStimulus(run_y[i], run_y[i], int'($urandom_range(1, 5)));
        end
        checkOutput("t6 gapped done", 96'(done), 96'(1));
        checkOutput("t6 gapped signature", 96'(signature), 96'(ref_sig));
        checkOutput("t6 gapped mismatch_cnt", 96'(mismatch_cnt), 96'(0));

        startRun(16'd4);
        for (int i = 0; i < 4; i++) begin
            applyStimulus(run_y[i], run_y[i], 0);
        end
        checkOutput("t6 gapfree signature", 96'(signature), 96'(ref_sig));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL global_timeout: got no finish required finish before 200000");
        $fatal(1, "[TB] timeout");
    end

endmodule
